div_issue_ctrl: RTL and testbench

//  Request front-end for the 16/8 sequential divider. Buffers dividend/divisor pairs
//  (valid/ready in), issues one-cycle div_start with held operands, captures

---
 rtl/div_pkg.sv | 32 +++
 rtl/div_req_fifo.sv | 46 ++++
 rtl/div_issue_ctrl.sv | 140 ++++++++++++++
 tb/tb_div_issue_ctrl.sv | 394 +++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/div_pkg.sv
// Shared types and widths for the 16/8 divider issue front-end.
package div_pkg;

  localparam int DIVIDEND_W = 16;
  localparam int DIVISOR_W  = 8;
  localparam int QUOT_W     = 8;
  localparam int REM_W      = 16;

  typedef enum logic {
    IDLE = 1'b0,
    WAIT = 1'b1
  } div_state_e;

  typedef struct packed {
    logic [DIVIDEND_W-1:0] dividend;
    logic [DIVISOR_W-1:0]  divisor;
  } div_req_t;

  typedef struct packed {
    logic [QUOT_W-1:0] quot;
    logic [REM_W-1:0]  rem;
    logic              dz;
    logic              ovf;
    logic              err;
  } div_rsp_t;

  // A quotient fits in QUOT_W bits only when the dividend's upper half is below the divisor.
  function automatic logic quot_overflow(input div_req_t req);
    return req.dividend[DIVIDEND_W-1 -: DIVISOR_W] >= req.divisor;
  endfunction

endpackage

// File: rtl/div_req_fifo.sv
// Request FIFO for div_issue_ctrl; pointers carry one extra wrap bit to tell full from empty.
module div_req_fifo
  import div_pkg::*;
#(
  parameter int FIFO_DEPTH = 4
) (
  input  logic     clk,
  input  logic     rst_n,
  input  logic     i_push,
  input  div_req_t i_data,
  input  logic     i_pop,
  output div_req_t o_data,
  output logic     o_full,
  output logic     o_empty
);

  localparam int AW = $clog2(FIFO_DEPTH);

  div_req_t      r_mem [FIFO_DEPTH];
  logic [AW:0]   r_wrPtr;
  logic [AW:0]   r_rdPtr;
  logic          w_doPush;
  logic          w_doPop;

  assign o_empty  = (r_wrPtr == r_rdPtr);
  assign o_full   = (r_wrPtr[AW] != r_rdPtr[AW]) && (r_wrPtr[AW-1:0] == r_rdPtr[AW-1:0]);
  assign w_doPush = i_push && !o_full;
  assign w_doPop  = i_pop && !o_empty;
  assign o_data   = r_mem[r_rdPtr[AW-1:0]];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wrPtr <= '0;
      r_rdPtr <= '0;
    end else begin
      if (w_doPush) r_wrPtr <= r_wrPtr + 1'b1;
      if (w_doPop)  r_rdPtr <= r_rdPtr + 1'b1;
    end
  end

  // Storage needs no reset: entries are only read once the pointers say they were written.
  always_ff @(posedge clk) begin
    if (w_doPush) r_mem[r_wrPtr[AW-1:0]] <= i_data;
  end

endmodule

// File: rtl/div_issue_ctrl.sv
// Issue controller for the 16/8 sequential divider: request FIFO, issue FSM, result register.
// Optional divider watchdog enabled by defining DIV_TIMEOUT_EN.
module div_issue_ctrl
  import div_pkg::*;
#(
  parameter int FIFO_DEPTH = 4
`ifdef DIV_TIMEOUT_EN
  ,
  parameter int TIMEOUT    = 32
`endif
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [15:0] in_dividend,
  input  logic [7:0]  in_divisor,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [7:0]  out_quot,
  output logic [15:0] out_rem,
  output logic        out_dz,
  output logic        out_ovf,
  output logic        out_err,
  output logic        div_start,
  output logic [15:0] div_x,
  output logic [7:0]  div_y,
  input  logic [7:0]  div_z,
  input  logic [15:0] div_r,
  input  logic        div_done,
  output logic        busy
);

  div_state_e            r_state;
  div_rsp_t              r_rsp;
  logic                  r_outValid;
  logic                  r_divStart;
  logic [DIVIDEND_W-1:0] r_divX;
  logic [DIVISOR_W-1:0]  r_divY;
  logic                  r_pendOvf;

  div_req_t              w_inReq;
  div_req_t              w_head;
  logic                  w_full;
  logic                  w_empty;
  logic                  w_push;
  logic                  w_pop;

`ifdef DIV_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT + 1);
  logic [CNT_W-1:0]      r_waitCnt;
`endif

  assign w_inReq = '{dividend: in_dividend, divisor: in_divisor};
  assign w_push  = in_valid && !w_full;
  // The result register must be free before another request leaves the FIFO.
  assign w_pop   = (r_state == IDLE) && !w_empty && !r_outValid;

  div_req_fifo #(
    .FIFO_DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_push  (w_push),
    .i_data  (w_inReq),
    .i_pop   (w_pop),
    .o_data  (w_head),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  // div_done is ignored in the start cycle: the divider cannot finish the divide it is just being handed.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= IDLE;
      r_rsp      <= '0;
      r_outValid <= 1'b0;
      r_divStart <= 1'b0;
      r_divX     <= '0;
      r_divY     <= '0;
      r_pendOvf  <= 1'b0;
`ifdef DIV_TIMEOUT_EN
      r_waitCnt  <= '0;
`endif
    end else begin
      r_divStart <= 1'b0;
      if (r_outValid && out_ready) r_outValid <= 1'b0;
      case (r_state)
        IDLE: begin
`ifdef DIV_TIMEOUT_EN
          r_waitCnt <= '0;
`endif
          if (w_pop) begin
            if (w_head.divisor == '0) begin
              r_rsp      <= '{quot: {QUOT_W{1'b1}}, rem: w_head.dividend,
                              dz: 1'b1, ovf: 1'b0, err: 1'b0};
              r_outValid <= 1'b1;
            end else begin
              r_divX     <= w_head.dividend;
              r_divY     <= w_head.divisor;
              r_pendOvf  <= quot_overflow(w_head);
              r_divStart <= 1'b1;
              r_state    <= WAIT;
            end
          end
        end
        WAIT: begin
          if (div_done && !r_divStart) begin
            r_rsp      <= '{quot: div_z, rem: div_r, dz: 1'b0, ovf: r_pendOvf, err: 1'b0};
            r_outValid <= 1'b1;
            r_state    <= IDLE;
          end
`ifdef DIV_TIMEOUT_EN
          else if (r_waitCnt == CNT_W'(TIMEOUT - 1)) begin
            r_rsp      <= '{quot: '0, rem: '0, dz: 1'b0, ovf: r_pendOvf, err: 1'b1};
            r_outValid <= 1'b1;
            r_state    <= IDLE;
          end else begin
            r_waitCnt  <= r_waitCnt + 1'b1;
          end
`endif
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign in_ready  = !w_full;
  assign out_valid = r_outValid;
  assign out_quot  = r_rsp.quot;
  assign out_rem   = r_rsp.rem;
  assign out_dz    = r_rsp.dz;
  assign out_ovf   = r_rsp.ovf;
  assign out_err   = r_rsp.err;
  assign div_start = r_divStart;
  assign div_x     = r_divX;
  assign div_y     = r_divY;
  assign busy      = (r_state != IDLE) || !w_empty || r_outValid;

endmodule

// File: tb/tb_div_issue_ctrl.sv
// Self-checking bench for div_issue_ctrl with a latency-17 divider stub and a request-order result model.
module tb_div_issue_ctrl;
  import div_pkg::*;

  localparam int STUB_LAT = 17;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_dividend;
  logic [7:0]  in_divisor;
  logic        out_valid;
  logic        out_ready;
  logic [7:0]  out_quot;
  logic [15:0] out_rem;
  logic        out_dz;
  logic        out_ovf;
  logic        out_err;
  logic        div_start;
  logic [15:0] div_x;
  logic [7:0]  div_y;
  logic [7:0]  div_z;
  logic [15:0] div_r;
  logic        div_done;
  logic        busy;

  int checks = 0;
  int errors = 0;
  int cycleNo = 0;
  int startCount = 0;
  int doneCount = 0;
  int lastStartCycle = 0;
  int lastDoneCycle = 0;
  bit stubSilent = 1'b0;

  div_req_t reqQ[$];
  div_req_t issueQ[$];

  div_issue_ctrl #(.FIFO_DEPTH(4)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_dividend (in_dividend),
    .in_divisor  (in_divisor),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_quot    (out_quot),
    .out_rem     (out_rem),
    .out_dz      (out_dz),
    .out_ovf     (out_ovf),
    .out_err     (out_err),
    .div_start   (div_start),
    .div_x       (div_x),
    .div_y       (div_y),
    .div_z       (div_z),
    .div_r       (div_r),
    .div_done    (div_done),
    .busy        (busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cycleNo <= cycleNo + 1;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, required 0x%0h (cycle %0d)", name, actual, expected, cycleNo);
    end
  endtask

  task automatic failNow(input string name, input string what);
    checks++;
    errors++;
    $display("[TB] FAIL %s: %s (cycle %0d)", name, what, cycleNo);
  endtask

  // Expected result from the arithmetic meaning of a request, not from how the DUT computes it.
  function automatic div_rsp_t expectRsp(input div_req_t r, input bit timedOut);
    div_rsp_t e;
    int q;
    e = '0;
    if (r.divisor == 0) begin
      e.quot = 8'hFF;
      e.rem  = r.dividend;
      e.dz   = 1'b1;
    end else begin
      q     = int'(r.dividend) / int'(r.divisor);
      e.ovf = (q > 255);
      if (timedOut) begin
        e.err = 1'b1;
      end else begin
        e.quot = 8'(q);
        e.rem  = 16'(int'(r.dividend) % int'(r.divisor));
      end
    end
    return e;
  endfunction

  // Divider stub: captures operands on div_start, answers STUB_LAT cycles later; it is never reset.
  initial begin : divStub
    int cnt;
    logic [15:0] sx;
    logic [15:0] sy;
    cnt = 0; sx = '0; sy = 16'd1;
    div_done = 1'b0; div_z = '0; div_r = '0;
    forever begin
      @(negedge clk);
      div_done = 1'b0;
      if (cnt > 0) begin
        cnt--;
        if (cnt == 0) begin
          div_done = 1'b1;
          div_z = 8'(sx / sy);
          div_r = 16'(sx % sy);
          lastDoneCycle = cycleNo;
          doneCount++;
        end
      end
      if (div_start) begin
        startCount++;
        lastStartCycle = cycleNo;
        sx = div_x;
        sy = {8'd0, div_y};
        if (!stubSilent && div_y != 0) cnt = STUB_LAT;
      end
    end
  end

  // Compare process: every cycle out of reset, checks busy, issue order, operand hold and results.
  initial begin : compareProc
    logic [15:0] heldX;
    logic [7:0]  heldY;
    bit inFlight;
    bit prevStart;
    div_rsp_t exp;
    heldX = '0; heldY = '0; inFlight = 0; prevStart = 0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        reqQ.delete();
        issueQ.delete();
        inFlight = 0;
        prevStart = 0;
      end else begin
        checkOutput("busy", busy, (reqQ.size() != 0));
        if (div_start) begin
          checkOutput("start_pulse_width", prevStart, 0);
          if (issueQ.size() == 0) begin
            failNow("start_unexpected", "div_start with no nonzero-divisor request pending");
          end else begin
            checkOutput("div_x_issue", div_x, issueQ[0].dividend);
            checkOutput("div_y_issue", div_y, issueQ[0].divisor);
            heldX = issueQ[0].dividend;
            heldY = issueQ[0].divisor;
            void'(issueQ.pop_front());
            inFlight = 1;
          end
        end else if (inFlight) begin
          checkOutput("div_x_hold", div_x, heldX);
          checkOutput("div_y_hold", div_y, heldY);
        end
        prevStart = div_start;
        if (out_valid) begin
          inFlight = 0;
          if (reqQ.size() == 0) begin
            failNow("result_unexpected", "out_valid with no request outstanding");
          end else begin
            exp = expectRsp(reqQ[0], stubSilent && (reqQ[0].divisor != 0));
            checkOutput("result", {5'd0, out_quot, out_rem, out_dz, out_ovf, out_err}, {5'd0, exp});
            if (out_ready) void'(reqQ.pop_front());
          end
        end
        if (in_valid && in_ready) begin
          reqQ.push_back('{dividend: in_dividend, divisor: in_divisor});
          if (in_divisor != 0) issueQ.push_back('{dividend: in_dividend, divisor: in_divisor});
        end
      end
    end
  end

  task automatic waitCycles(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic applyStimulus(input logic [15:0] x, input logic [7:0] y, output int acceptCycle);
    bit took;
    took = 0;
    acceptCycle = -1;
    in_valid = 1'b1;
    in_dividend = x;
    in_divisor = y;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (in_ready) begin
        took = 1;
        acceptCycle = cycleNo;
        break;
      end
    end
    if (!took) failNow("accept_timeout", "in_ready never high");
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic waitOutValid(input int maxCycles, input string name, output int seenCycle);
    seenCycle = -1;
    for (int i = 0; i < maxCycles; i++) begin
      @(negedge clk);
      if (out_valid) begin
        seenCycle = cycleNo;
        break;
      end
    end
    if (seenCycle < 0) failNow(name, "out_valid never high within bound");
  endtask

  task automatic waitStart(input int maxCycles, input string name);
    bit seen;
    seen = 0;
    for (int i = 0; i < maxCycles; i++) begin
      @(negedge clk);
      if (div_start) begin
        seen = 1;
        break;
      end
    end
    if (!seen) failNow(name, "div_start never high within bound");
  endtask

  initial begin : watchdog
    repeat (20000) @(posedge clk);
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin : mainProc
    int acc;
    int seen;
    int startsBefore;
    int accepted;
    int got;
    int validSeen;
    logic [7:0]  quots [5];
    logic [15:0] t4X [6];
    logic [7:0]  t4Y [6];
    logic [7:0]  t4Q [5];

    t4X = '{16'd200, 16'd5000, 16'd60000, 16'hFFFF, 16'd77, 16'd999};
    t4Y = '{8'd3, 8'd0, 8'd250, 8'hFF, 8'd77, 8'd3};
    t4Q = '{8'd66, 8'hFF, 8'd240, 8'd1, 8'd1};

    rst_n = 1'b0; in_valid = 1'b0; in_dividend = '0; in_divisor = '0; out_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    checkOutput("rst_out_valid", out_valid, 0);
    checkOutput("rst_div_start", div_start, 0);
    checkOutput("rst_out_flags", {out_dz, out_ovf, out_err}, 0);
    checkOutput("rst_out_data", {out_quot, out_rem}, 0);
    checkOutput("rst_div_xy", {div_x, div_y}, 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    checkOutput("rst_in_ready", in_ready, 1);
    checkOutput("rst_busy", busy, 0);
    @(posedge clk);
    #1;

    $display("[TB] test 1: 100/7");
    startsBefore = startCount;
    applyStimulus(16'd100, 8'd7, acc);
    waitOutValid(60, "t1_valid", seen);
    checkOutput("t1_quot", out_quot, 14);
    checkOutput("t1_rem", out_rem, 2);
    checkOutput("t1_flags", {out_dz, out_ovf, out_err}, 0);
    checkOutput("t1_done_to_valid", seen - lastDoneCycle, 1);
    checkOutput("t1_starts", startCount - startsBefore, 1);
    @(posedge clk);
    #1;

    $display("[TB] test 2: 1234/0");
    startsBefore = startCount;
    applyStimulus(16'd1234, 8'd0, acc);
    waitOutValid(20, "t2_valid", seen);
    checkOutput("t2_quot", out_quot, 8'hFF);
    checkOutput("t2_rem", out_rem, 1234);
    checkOutput("t2_dz", {out_dz, out_ovf}, 2'b10);
    checkOutput("t2_accept_to_valid", seen - acc, 2);
    checkOutput("t2_no_start", startCount - startsBefore, 0);
    @(posedge clk);
    #1;

    $display("[TB] test 3: overflow boundary");
    startsBefore = startCount;
    applyStimulus(16'h1200, 8'h10, acc);
    waitOutValid(60, "t3a_valid", seen);
    checkOutput("t3a_ovf", out_ovf, 1);
    checkOutput("t3a_forward", {out_quot, out_rem}, {8'h20, 16'h0000});
    @(posedge clk);
    #1;
    applyStimulus(16'h0FFF, 8'h10, acc);
    waitOutValid(60, "t3b_valid", seen);
    checkOutput("t3b_ovf", out_ovf, 0);
    checkOutput("t3b_result", {out_quot, out_rem}, {8'd255, 16'd15});
    checkOutput("t3_starts", startCount - startsBefore, 2);
    @(posedge clk);
    #1;

    $display("[TB] test 4: backpressure with full FIFO");
    out_ready = 1'b0;
    accepted = 0;
    for (int i = 0; i < 6; i++) begin
      in_valid = 1'b1;
      in_dividend = t4X[i];
      in_divisor = t4Y[i];
      @(negedge clk);
      if (in_ready) accepted++;
      if (i == 5) checkOutput("t4_ready_low_6th", in_ready, 0);
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    checkOutput("t4_accepted", accepted, 5);
    waitCycles(25);
    checkOutput("t4_result_held", out_valid, 1);
    checkOutput("t4_still_full", in_ready, 0);
    out_ready = 1'b1;
    got = 0;
    for (int i = 0; i < 200 && got < 5; i++) begin
      @(negedge clk);
      if (out_valid) begin
        quots[got] = out_quot;
        got++;
      end
    end
    @(posedge clk);
    #1;
    checkOutput("t4_count", got, 5);
    for (int i = 0; i < 5; i++) checkOutput($sformatf("t4_order_%0d", i), quots[i], t4Q[i]);

    $display("[TB] test 5: reset while waiting on the divider");
    applyStimulus(16'd500, 8'd9, acc);
    waitStart(20, "t5_start");
    waitCycles(5);
    rst_n = 1'b0;
    waitCycles(2);
    rst_n = 1'b1;
    validSeen = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (out_valid) validSeen++;
    end
    checkOutput("t5_no_result", validSeen, 0);
    checkOutput("t5_in_ready", in_ready, 1);
    checkOutput("t5_idle", {busy, out_valid}, 0);
    @(posedge clk);
    #1;
    applyStimulus(16'd30, 8'd4, acc);
    waitOutValid(60, "t5_after_valid", seen);
    checkOutput("t5_after_result", {out_quot, out_rem}, {8'd7, 16'd2});
    @(posedge clk);
    #1;

`ifdef DIV_TIMEOUT_EN
    $display("[TB] test 6: divider timeout");
    stubSilent = 1'b1;
    applyStimulus(16'd50, 8'd5, acc);
    waitOutValid(80, "t6_valid", seen);
    checkOutput("t6_start_to_err", seen - lastStartCycle, 32);
    checkOutput("t6_err", {out_err, out_quot, out_rem}, {1'b1, 8'd0, 16'd0});
    @(posedge clk);
    #1;
    stubSilent = 1'b0;
    applyStimulus(16'd90, 8'd9, acc);
    waitOutValid(60, "t6_next_valid", seen);
    checkOutput("t6_next_result", {out_err, out_quot, out_rem}, {1'b0, 8'd10, 16'd0});
    @(posedge clk);
    #1;
`endif

    waitCycles(3);
    checkOutput("end_idle", busy, 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
